// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO control unit: request op codes, FSM states
// and small op-classification helpers used by the controller.
package mul_hilo_ctrl_pkg;

   localparam int OP_W   = 4;
   localparam int DATA_W = 32;

   typedef enum logic [OP_W-1:0] {
      OP_MULT  = 4'd0,
      OP_MULTU = 4'd1,
      OP_MADD  = 4'd2,
      OP_MADDU = 4'd3,
      OP_MSUB  = 4'd4,
      OP_MSUBU = 4'd5,
      OP_MTHI  = 4'd6,
      OP_MTLO  = 4'd7
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACC  = 2'd2
   } state_t;

   // Plain multiplies that write the product straight into HI/LO.
   function automatic logic isMulOnly(input logic [OP_W-1:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic isAccum(input logic [OP_W-1:0] op);
      return (op == OP_MADD) || (op == OP_MADDU) ||
             (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   function automatic logic isSubOp(input logic [OP_W-1:0] op);
      return (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   function automatic logic isSignedOp(input logic [OP_W-1:0] op);
      return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

endpackage

// File: rtl/mul_hilo_ctrl_mul.sv
// Two-stage 32x32 multiplier: partial products are registered on every edge,
// and the final 64-bit sum is formed combinationally in the following cycle.
module mul (
   input  logic        mul_clk,
   input  logic        resetn,
   input  logic        mul_signed,
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic [63:0] result
);

   logic        w_xSign;
   logic        w_ySign;
   logic [63:0] w_xExt64;
   logic [63:0] w_yLo64;
   logic [47:0] w_xExt48;
   logic [47:0] w_yHi48;
   logic [63:0] w_ppLo;
   logic [47:0] w_ppHi;
   logic [63:0] r_ppLo;
   logic [47:0] r_ppHi;

   // y is split into an unsigned low half and a (possibly signed) high half,
   // so the high partial product only needs 48 bits modulo 2^48.
   assign w_xSign  = mul_signed & x[31];
   assign w_ySign  = mul_signed & y[31];
   assign w_xExt64 = {{32{w_xSign}}, x};
   assign w_yLo64  = {48'd0, y[15:0]};
   assign w_xExt48 = {{16{w_xSign}}, x};
   assign w_yHi48  = {{32{w_ySign}}, y[31:16]};
   assign w_ppLo   = w_xExt64 * w_yLo64;
   assign w_ppHi   = w_xExt48 * w_yHi48;

   always_ff @(posedge mul_clk) begin
      if (!resetn) begin
         r_ppLo <= '0;
         r_ppHi <= '0;
      end else begin
         r_ppLo <= w_ppLo;
         r_ppHi <= w_ppHi;
      end
   end

   assign result = r_ppLo + {r_ppHi, 16'd0};

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Execute-stage HI/LO controller: issues multiply-class ops to the multiplier,
// commits products or accumulated sums to HI/LO, and handles MTHI/MTLO.
module mul_hilo_ctrl
   import mul_hilo_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   req_op,
   input  logic [DATA_W-1:0] req_src1,
   input  logic [DATA_W-1:0] req_src2,
   input  logic              flush,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              busy
);

   state_t            r_state;
   state_t            w_stateNext;
   logic [OP_W-1:0]   r_op;
   logic [63:0]       r_prod;
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;

   logic              w_accept;
   logic              w_mulResetn;
   logic              w_mulSigned;
   logic [63:0]       w_product;
   logic [63:0]       w_hiLo;
   logic [63:0]       w_sum;

   assign req_ready   = (r_state == ST_IDLE);
   assign busy        = (r_state != ST_IDLE);
   assign w_accept    = req_valid & req_ready & ~flush;
   assign w_mulResetn = ~reset;
   assign w_mulSigned = isSignedOp(req_op);

   mul u_mul (
      .mul_clk    (clk),
      .resetn     (w_mulResetn),
      .mul_signed (w_mulSigned),
      .x          (req_src1),
      .y          (req_src2),
      .result     (w_product)
   );

   // Accumulate path wraps modulo 2^64 for both signed and unsigned variants.
   assign w_hiLo = {r_hi, r_lo};
   assign w_sum  = isSubOp(r_op) ? (w_hiLo - r_prod) : (w_hiLo + r_prod);

   // Next-state logic; flush always wins over any pending commit.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && (isMulOnly(req_op) || isAccum(req_op))) begin
               w_stateNext = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (flush || !isAccum(r_op)) begin
               w_stateNext = ST_IDLE;
            end else begin
               w_stateNext = ST_ACC;
            end
         end
         ST_ACC: begin
            w_stateNext = ST_IDLE;
         end
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_op    <= '0;
         r_prod  <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_state <= w_stateNext;
         if (w_accept) begin
            r_op <= req_op;
            if (req_op == OP_MTHI) begin
               r_hi <= req_src1;
            end
            if (req_op == OP_MTLO) begin
               r_lo <= req_src1;
            end
         end
         if ((r_state == ST_WAIT) && !flush) begin
            if (isAccum(r_op)) begin
               r_prod <= w_product;
            end else begin
               {r_hi, r_lo} <= w_product;
            end
         end
         if ((r_state == ST_ACC) && !flush) begin
            {r_hi, r_lo} <= w_sum;
         end
      end
   end

   assign hi = r_hi;
   assign lo = r_lo;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl: a reference model predicts HI/LO for
// each accepted op and a queue holds the expectations until commit time.
module tb_mul_hilo_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_src1;
   logic [31:0] req_src2;
   logic        flush;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;

   typedef struct {
      logic [63:0] hiLo;
      int          busyCycles;
   } exp_t;

   exp_t        expQ[$];
   logic [63:0] modelHiLo;
   int          testsRun    = 0;
   int          testsFailed = 0;

   always #5 clk = ~clk;

   mul_hilo_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_src1  (req_src1),
      .req_src2  (req_src2),
      .flush     (flush),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference model: full-width products formed from sign/zero-extended operands.
   function automatic exp_t predict(input logic [3:0] op, input logic [31:0] s1,
                                    input logic [31:0] s2, input logic [63:0] cur);
      exp_t        e;
      logic        sgn;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] prod;
      sgn  = (op == 4'd0) || (op == 4'd2) || (op == 4'd4);
      a    = sgn ? {{32{s1[31]}}, s1} : {32'd0, s1};
      b    = sgn ? {{32{s2[31]}}, s2} : {32'd0, s2};
      prod = a * b;
      e.hiLo       = cur;
      e.busyCycles = 0;
      case (op)
         4'd0, 4'd1: begin e.hiLo = prod;       e.busyCycles = 1; end
         4'd2, 4'd3: begin e.hiLo = cur + prod; e.busyCycles = 2; end
         4'd4, 4'd5: begin e.hiLo = cur - prod; e.busyCycles = 2; end
         4'd6:       e.hiLo = {s1, cur[31:0]};
         4'd7:       e.hiLo = {cur[63:32], s1};
         default:    e.hiLo = cur;
      endcase
      return e;
   endfunction

   task automatic issueOp(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_src1  = s1;
      req_src2  = s2;
      checkOutput("req_ready before accept", {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic pushExpected(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2);
      exp_t e;
      e = predict(op, s1, s2, modelHiLo);
      modelHiLo = e.hiLo;
      expQ.push_back(e);
   endtask

   task automatic checkCompletion(input string tag);
      exp_t e;
      if (expQ.size() == 0) begin
         checkOutput({tag, " queue empty"}, 64'd1, 64'd0);
         return;
      end
      e = expQ.pop_front();
      for (int c = 0; c < e.busyCycles; c++) begin
         @(negedge clk);
         checkOutput({tag, " busy"}, {63'd0, busy}, 64'd1);
      end
      @(negedge clk);
      checkOutput({tag, " busy done"}, {63'd0, busy}, 64'd0);
      checkOutput({tag, " ready done"}, {63'd0, req_ready}, 64'd1);
      checkOutput({tag, " hilo"}, {hi, lo}, e.hiLo);
   endtask

   task automatic applyStimulus(input string tag, input logic [3:0] op,
                                input logic [31:0] s1, input logic [31:0] s2);
      issueOp(op, s1, s2);
      pushExpected(op, s1, s2);
      checkCompletion(tag);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_op    = 4'd0;
      req_src1  = 32'd0;
      req_src2  = 32'd0;
      flush     = 1'b0;
      modelHiLo = 64'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset hilo", {hi, lo}, 64'd0);
      checkOutput("reset busy", {63'd0, busy}, 64'd0);
      checkOutput("reset ready", {63'd0, req_ready}, 64'd1);

      applyStimulus("MULT", 4'd0, 32'hFFFF_FFFF, 32'h0000_0002);
      applyStimulus("MULTU", 4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
      checkOutput("MULTU const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

      applyStimulus("MTHI", 4'd6, 32'd0, 32'd0);
      applyStimulus("MTLO", 4'd7, 32'd5, 32'd0);
      applyStimulus("MADD", 4'd2, 32'd3, 32'd4);
      checkOutput("MADD const", {hi, lo}, 64'h0000_0000_0000_0011);
      applyStimulus("MSUBU", 4'd5, 32'd1, 32'h12);
      checkOutput("MSUBU const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
      applyStimulus("MADDU wrap", 4'd3, 32'd1, 32'd1);
      checkOutput("MADDU wrap const", {hi, lo}, 64'd0);
      applyStimulus("MSUB neg", 4'd4, 32'hFFFF_FFFD, 32'd7);
      applyStimulus("op 12 noop", 4'd12, 32'hDEAD_BEEF, 32'd1);

      // Flush during WAIT cancels the multiply.
      issueOp(4'd0, 32'd7, 32'd7);
      flush = 1'b1;
      @(negedge clk);
      checkOutput("flush wait busy", {63'd0, busy}, 64'd1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      checkOutput("flush ready", {63'd0, req_ready}, 64'd1);
      checkOutput("flush busy", {63'd0, busy}, 64'd0);
      checkOutput("flush hilo", {hi, lo}, modelHiLo);

      // Flush with a request in IDLE: nothing accepted.
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = 4'd6;
      req_src1  = 32'h1234_5678;
      flush     = 1'b1;
      @(posedge clk);
      #1;
      req_op = 4'd0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      flush     = 1'b0;
      @(negedge clk);
      checkOutput("idle flush busy", {63'd0, busy}, 64'd0);
      checkOutput("idle flush hilo", {hi, lo}, modelHiLo);

      // Back-to-back MULTs with req_valid held.
      issueOp(4'd0, 32'd6, 32'hFFFF_FFF9);
      pushExpected(4'd0, 32'd6, 32'hFFFF_FFF9);
      req_valid = 1'b1;
      req_op    = 4'd1;
      req_src1  = 32'h8000_0001;
      req_src2  = 32'h0001_0003;
      @(negedge clk);
      checkOutput("b2b ready T+1", {63'd0, req_ready}, 64'd0);
      checkOutput("b2b busy T+1", {63'd0, busy}, 64'd1);
      @(negedge clk);
      checkOutput("b2b ready T+2", {63'd0, req_ready}, 64'd1);
      begin
         exp_t e;
         e = expQ.pop_front();
         checkOutput("b2b first hilo", {hi, lo}, e.hiLo);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      pushExpected(4'd1, 32'h8000_0001, 32'h0001_0003);
      checkCompletion("b2b second");

      // Reset during ACC of an MSUB aborts with no late commit.
      issueOp(4'd4, 32'd5, 32'd6);
      @(negedge clk);
      @(negedge clk);
      checkOutput("pre-reset acc busy", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      modelHiLo = 64'd0;
      checkOutput("acc reset hilo", {hi, lo}, 64'd0);
      checkOutput("acc reset ready", {63'd0, req_ready}, 64'd1);
      checkOutput("acc reset busy", {63'd0, busy}, 64'd0);
      repeat (3) @(negedge clk);
      checkOutput("no late commit", {hi, lo}, 64'd0);

      for (int i = 0; i < 10; i++) begin
         logic [3:0]  op;
         logic [31:0] s1;
         logic [31:0] s2;
         op = 4'($urandom_range(0, 15));
         s1 = $urandom;
         s2 = $urandom;
         applyStimulus($sformatf("rand%0d op%0d", i, op), op, s1, s2);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
